// File: rtl/off_delay_timer.sv
// -----------------------------------------------------------------------------
// off_delay_timer
//
// Off-delay (falling-edge stretch) timer. delay_output follows signal_in high
// with one clk of latency. After signal_in falls, it stays high until cnt_size
// cnt_step ticks have been counted, then falls one clk later. A new high level
// on signal_in during the hold restarts the cycle.
//
// Optional feature macro: OFF_DELAY_CNT_OUT_EN
//   When defined, the hold_cnt port exists and mirrors the internal hold
//   counter. When undefined, the port is absent and behaviour is unchanged.
//
// Ports
//   clk           in   fast core clock
//   reset         in   asynchronous, active-high reset
//   signal_in     in   level to stretch (already synchronized / de-glitched)
//   cnt_step      in   one-clk tick that advances the hold count
//   cnt_size      in   [CNT_SIZE] number of ticks to hold after the drop
//   delay_output  out  signal_in with its falling edge delayed
//   busy          out  high while a hold countdown is running
//   expire_pulse  out  one-clk pulse when a hold completes
//   hold_cnt      out  [CNT_SIZE] current hold count (OFF_DELAY_CNT_OUT_EN only)
// -----------------------------------------------------------------------------
module off_delay_timer #(
  parameter int CNT_SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                signal_in,
  input  logic                cnt_step,
  input  logic [CNT_SIZE-1:0] cnt_size,
  output logic                delay_output,
  output logic                busy,
`ifdef OFF_DELAY_CNT_OUT_EN
  output logic                expire_pulse,
  output logic [CNT_SIZE-1:0] hold_cnt
`else
  output logic                expire_pulse
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [CNT_SIZE-1:0] CNT_ZERO = {CNT_SIZE{1'b0}};
  localparam logic [CNT_SIZE-1:0] CNT_ONE  = {{(CNT_SIZE-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [CNT_SIZE-1:0] cnt_q, cnt_d;
  logic                delay_output_q, delay_output_d;
  logic                expire_pulse_q, expire_pulse_d;

  // Hold is complete once the count reaches the live (unlatched) size. Using
  // >= makes a size lowered below the current count expire on the next edge.
  logic                hold_done_s;
  assign hold_done_s = (cnt_q >= cnt_size);

  // Next-state, counter and output decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    delay_output_d = delay_output_q;
    expire_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (signal_in) begin
          state_d        = ACTIVE;
          delay_output_d = 1'b1;
        end else begin
          delay_output_d = 1'b0;
        end
      end

      ACTIVE: begin
        cnt_d          = CNT_ZERO;
        delay_output_d = 1'b1;
        if (signal_in) begin
          state_d = ACTIVE;
        end else if (cnt_size == CNT_ZERO) begin
          // Zero-length hold: drop straight out, still reporting expiry.
          state_d        = IDLE;
          delay_output_d = 1'b0;
          expire_pulse_d = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        delay_output_d = 1'b1;
        if (signal_in) begin
          // Retrigger wins over an expiry in the same cycle.
          state_d = ACTIVE;
          cnt_d   = CNT_ZERO;
        end else if (hold_done_s) begin
          state_d        = IDLE;
          cnt_d          = CNT_ZERO;
          delay_output_d = 1'b0;
          expire_pulse_d = 1'b1;
        end else if (cnt_step) begin
          // cnt < cnt_size here, so the increment can never pass the size
          // or wrap.
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d        = IDLE;
        cnt_d          = CNT_ZERO;
        delay_output_d = 1'b0;
        expire_pulse_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any hold silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= CNT_ZERO;
      delay_output_q <= 1'b0;
      expire_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      delay_output_q <= delay_output_d;
      expire_pulse_q <= expire_pulse_d;
    end
  end

  assign delay_output = delay_output_q;
  assign expire_pulse = expire_pulse_q;
  // Decoded straight from the state register so it tracks HOLD with no lag.
  assign busy         = (state_q == HOLD);

`ifdef OFF_DELAY_CNT_OUT_EN
  assign hold_cnt = cnt_q;
`endif

endmodule
